// File: rtl/read_data_dispatcher_if.sv
// Bundle of the read-data dispatcher's FIFO, backend and per-core delivery signals.
// master = dispatcher side, slave = FIFO/backend/core side.
interface read_data_dispatcher_if #(
    parameter int unsigned DATA_WIDTH     = 128,
    parameter int unsigned CORE_NUM_WIDTH = 2
);
    localparam int unsigned NUM_CORES = 1 << CORE_NUM_WIDTH;

    logic [CORE_NUM_WIDTH-1:0] i_core_num;
    logic                      i_fifo_empty;
    logic                      o_fifo_rd_en;
    logic                      i_rdata_valid;
    logic [DATA_WIDTH-1:0]     i_rdata;
    logic                      o_rdata_ready;
    logic [NUM_CORES-1:0]      o_core_valid;
    logic [DATA_WIDTH-1:0]     o_core_data;
    logic [NUM_CORES-1:0]      i_core_ready;
    logic                      o_orphan_err;
    logic                      o_timeout_err;

    modport master (
        input  i_core_num, i_fifo_empty, i_rdata_valid, i_rdata, i_core_ready,
        output o_fifo_rd_en, o_rdata_ready, o_core_valid, o_core_data,
        output o_orphan_err, o_timeout_err
    );

    modport slave (
        output i_core_num, i_fifo_empty, i_rdata_valid, i_rdata, i_core_ready,
        input  o_fifo_rd_en, o_rdata_ready, o_core_valid, o_core_data,
        input  o_orphan_err, o_timeout_err
    );
endinterface

// File: rtl/read_data_dispatcher.sv
// Pairs in-order DRAM read beats with the core number at the FIFO head and delivers them.
// Optional stall watchdog enabled by defining READ_DISPATCH_TIMEOUT_EN.
module read_data_dispatcher #(
    parameter int unsigned DATA_WIDTH     = 128,
    parameter int unsigned CORE_NUM_WIDTH = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    read_data_dispatcher_if.master bus
);
    localparam int unsigned NUM_CORES = 1 << CORE_NUM_WIDTH;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                    state_q, state_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [CORE_NUM_WIDTH-1:0] held_core_q, held_core_d;
    logic                      orphan_q, orphan_d;

    logic deliver;
    logic accept;
    logic orphan_drop;

    always_comb begin
        deliver     = (state_q == StSend) && bus.i_core_ready[held_core_q];
        accept      = bus.i_rdata_valid && !bus.i_fifo_empty &&
                      ((state_q == StIdle) || deliver);
        // A beat with no FIFO entry to pair with is swallowed so the backend never stalls on it.
        orphan_drop = (state_q == StIdle) && bus.i_rdata_valid && bus.i_fifo_empty;

        state_d     = state_q;
        data_d      = data_q;
        held_core_d = held_core_q;
        orphan_d    = orphan_q | orphan_drop;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    data_d      = bus.i_rdata;
                    held_core_d = bus.i_core_num;
                    state_d     = StSend;
                end
            end
            StSend: begin
                if (accept) begin
                    data_d      = bus.i_rdata;
                    held_core_d = bus.i_core_num;
                end else if (deliver) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            data_q      <= '0;
            held_core_q <= '0;
            orphan_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            held_core_q <= held_core_d;
            orphan_q    <= orphan_d;
        end
    end

    always_comb begin
        bus.o_rdata_ready = accept || orphan_drop;
        bus.o_fifo_rd_en  = accept;
        bus.o_core_valid  = (state_q == StSend) ? (NUM_CORES'(1) << held_core_q) : '0;
        bus.o_core_data   = data_q;
        bus.o_orphan_err  = orphan_q;
    end

`ifdef READ_DISPATCH_TIMEOUT_EN
    logic [7:0] wd_cnt_q, wd_cnt_d;
    logic       timeout_q, timeout_d;

    always_comb begin
        wd_cnt_d = '0;
        if ((state_q == StSend) && !deliver) begin
            // Saturate so a very long stall cannot wrap back below the limit.
            wd_cnt_d = (wd_cnt_q == 8'hFF) ? wd_cnt_q : wd_cnt_q + 8'd1;
        end
        timeout_d = timeout_q | (wd_cnt_q == 8'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.o_timeout_err = timeout_q;
`else
    assign bus.o_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_read_data_dispatcher.sv
// Randomized bench for read_data_dispatcher; a queue-based model of the FIFO and the
// single held beat predicts every handshake and delivery.
module tb_read_data_dispatcher;
    localparam int unsigned DW  = 128;
    localparam int unsigned CNW = 2;
    localparam int unsigned TO  = 8;

    logic clk;
    logic rst_n;

    read_data_dispatcher_if #(.DATA_WIDTH(DW), .CORE_NUM_WIDTH(CNW)) bus ();

    read_data_dispatcher #(
        .DATA_WIDTH    (DW),
        .CORE_NUM_WIDTH(CNW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: outstanding core numbers, at most one beat in flight toward a core.
    logic [CNW-1:0] fifo[$];
    bit             holding;
    logic [CNW-1:0] held_core;
    logic [DW-1:0]  held_data;
    bit             orphan;
    int             stall_cnt;
    bit             terr;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_beat();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic do_reset();
        bus.i_rdata_valid = 1'b0;
        bus.i_rdata       = '0;
        bus.i_core_ready  = '0;
        bus.i_fifo_empty  = 1'b1;
        bus.i_core_num    = '0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_core_valid", DW'(bus.o_core_valid), '0);
        check("rst_core_data", bus.o_core_data, '0);
        check("rst_orphan_err", DW'(bus.o_orphan_err), '0);
        check("rst_timeout_err", DW'(bus.o_timeout_err), '0);
        @(negedge clk);
        rst_n = 1'b1;
        fifo.delete();
        holding   = 0;
        held_core = '0;
        held_data = '0;
        orphan    = 0;
        stall_cnt = 0;
        terr      = 0;
        @(posedge clk);
        #1;
    endtask

    // One cycle: optionally enqueue a FIFO entry, drive the backend/cores, check, advance model.
    task automatic step(input bit valid, input logic [DW-1:0] data, input logic [3:0] rdy,
                        input bit push, input logic [CNW-1:0] pcore);
        bit exp_deliver;
        bit exp_accept;
        bit exp_orphan;
        bit empty;
        logic [3:0] exp_valid;
        if (push) fifo.push_back(pcore);
        empty             = (fifo.size() == 0);
        bus.i_rdata_valid = valid;
        bus.i_rdata       = data;
        bus.i_core_ready  = rdy;
        bus.i_fifo_empty  = empty;
        bus.i_core_num    = empty ? '0 : fifo[0];
        @(negedge clk);
        exp_deliver = holding && rdy[held_core];
        exp_accept  = valid && !empty && (!holding || exp_deliver);
        exp_orphan  = valid && empty && !holding;
        exp_valid   = holding ? (4'b0001 << held_core) : 4'b0000;
        check("rdata_ready", DW'(bus.o_rdata_ready), DW'(exp_accept || exp_orphan));
        check("fifo_rd_en", DW'(bus.o_fifo_rd_en), DW'(exp_accept));
        check("core_valid", DW'(bus.o_core_valid), DW'(exp_valid));
        if (holding) check("core_data", bus.o_core_data, held_data);
        check("orphan_err", DW'(bus.o_orphan_err), DW'(orphan));
`ifdef READ_DISPATCH_TIMEOUT_EN
        check("timeout_err", DW'(bus.o_timeout_err), DW'(terr));
        if (stall_cnt == int'(TO)) terr = 1;
        stall_cnt = (holding && !exp_deliver) ? stall_cnt + 1 : 0;
`else
        check("timeout_err", DW'(bus.o_timeout_err), '0);
`endif
        orphan = orphan || exp_orphan;
        if (exp_accept) begin
            held_core = fifo.pop_front();
            held_data = data;
            holding   = 1;
        end else if (exp_deliver) begin
            holding = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        do_reset();

        // Single beat to core 2.
        step(1, DW'(8'hA5), 4'b0100, 1, 2'd2);
        step(0, '0, 4'b0100, 0, 2'd0);
        step(0, '0, 4'b0100, 0, 2'd0);

        // Four back-to-back beats to cores 0,1,3,2.
        step(0, '0, 4'hF, 1, 2'd0);
        step(0, '0, 4'hF, 1, 2'd1);
        step(0, '0, 4'hF, 1, 2'd3);
        step(0, '0, 4'hF, 1, 2'd2);
        for (int i = 0; i < 4; i++) step(1, rand_beat(), 4'hF, 0, 2'd0);
        step(0, '0, 4'hF, 0, 2'd0);
        step(0, '0, 4'hF, 0, 2'd0);

        // Core 1 stalls for five cycles with the next beat pending.
        step(0, '0, 4'hF, 1, 2'd1);
        step(1, rand_beat(), 4'hF, 1, 2'd2);
        for (int i = 0; i < 5; i++) step(1, DW'(32'h1234_5678), 4'b1101, 0, 2'd0);
        step(1, DW'(32'h1234_5678), 4'hF, 0, 2'd0);
        step(0, '0, 4'hF, 0, 2'd0);
        step(0, '0, 4'hF, 0, 2'd0);

        // Stall core 0 long enough to trip the watchdog when enabled.
        step(1, rand_beat(), 4'b0000, 1, 2'd0);
        for (int i = 0; i < 12; i++) step(0, '0, 4'b0000, 0, 2'd0);
        step(0, '0, 4'hF, 0, 2'd0);
        step(0, '0, 4'hF, 0, 2'd0);

        // Orphan beat with empty FIFO, then normal traffic keeps the flag set.
        step(1, rand_beat(), 4'hF, 0, 2'd0);
        step(1, rand_beat(), 4'hF, 1, 2'd3);
        step(0, '0, 4'hF, 0, 2'd0);
        step(0, '0, 4'hF, 0, 2'd0);

        // Reset with a beat held; queued entries are lost, no pop without a valid beat.
        step(0, '0, 4'h0, 1, 2'd1);
        step(1, rand_beat(), 4'h0, 1, 2'd3);
        do_reset();
        step(0, '0, 4'hF, 1, 2'd2);
        step(1, rand_beat(), 4'hF, 0, 2'd0);
        step(0, '0, 4'hF, 0, 2'd0);

        // Randomized traffic with one mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            bit push;
            if (i == 1500) do_reset();
            push = (fifo.size() < 8) && ($urandom_range(0, 99) < 45);
            step($urandom_range(0, 99) < 55, rand_beat(), 4'($urandom_range(0, 15)),
                 push, 2'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
